fetch_stage: RTL

Instruction-fetch stage that sits directly downstream of the program counter and upstream of decode. It reads the current PC, fetches the instruction from instruction memory over a req/ready handshake, and holds it in the fetch/decode (F/D) pipeline register. It returns the per-cycle PC step to the program counter. That counter's register is always enabled, so this block stalls or redirects the PC purely through the step value.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_fd_latch.sv | 31 +++
 rtl/fetch_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage and the pipeline latches that reuse fd_latch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    // Fetch FSM: BOOT for one cycle after reset, RUN when idle, WAIT with a request outstanding.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Contents of the fetch/decode pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] pc;
    } fd_t;

    // PC increment for a normal sequential fetch.
    localparam logic [31:0] PC_STEP_ONE = 32'd1;

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// fd_latch: generic pipeline register with load, clear (to empty/NOP) and hold.
// Latency: 1 cycle from load to q.
// Backpressure: holds whenever neither load nor clear is asserted; clear wins over load.
module fd_latch
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  fd_t  d,
    output fd_t  q
);

    // Register update: reset empties everything, clear empties the slot but keeps the last pc.
    always_ff @(posedge clock) begin
        if (reset) begin
            q.valid <= 1'b0;
            q.insn  <= NOP_INSN;
            q.pc    <= 32'd0;
        end else if (clear) begin
            q.valid <= 1'b0;
            q.insn  <= NOP_INSN;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetches the instruction at pc_in from imem into the F/D register and returns the PC step.
// Latency: 1 cycle pc_in -> fd_* with zero-wait imem; 1 bubble on redirect. Optional FETCH_PERF_EN adds counters.
// Backpressure: dec_stall with a live F/D drops imem_req and forces pc_step to 0; imem wait also gives step 0.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IMEM_AW  = 12,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        pc_in,
    output logic [31:0]        pc_step,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_data,
    input  logic               dec_stall,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_target,
    output logic               fd_valid,
    output logic [31:0]        fd_insn,
    output logic [31:0]        fd_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    fd_t          fd_q;
    fd_t          fd_d;
    logic         space;
    logic         accept;
    logic         fd_load;
    logic         fd_clear;

    assign fd_valid  = fd_q.valid;
    assign fd_insn   = fd_q.insn;
    assign fd_pc     = fd_q.pc;
    assign imem_addr = pc_in[IMEM_AW-1:0];

    // Handshake: a request is only made when F/D can take the result and no redirect is pending.
    always_comb begin
        space    = !fd_q.valid || !dec_stall;
        imem_req = (state_q != BOOT) && space && !redirect_en;
        accept   = imem_req && imem_ready;
    end

    // PC step: redirect is a relative jump so the always-enabled PC lands on the target.
    always_comb begin
        pc_step = 32'd0;
        if (redirect_en) begin
            pc_step = redirect_target - pc_in;
        end else if (accept) begin
            pc_step = PC_STEP_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: WAIT only while a request is still being made and not yet answered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (imem_req && !imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (accept || redirect_en || !imem_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // F/D controls: flush on redirect, empty when decode drains it with nothing new arriving.
    always_comb begin
        fd_d.valid = 1'b1;
        fd_d.insn  = imem_data;
        fd_d.pc    = pc_in;
        fd_load    = accept;
        fd_clear   = redirect_en || (fd_q.valid && !dec_stall && !accept);
    end

    fd_latch #(
        .NOP_INSN (NOP_INSN)
    ) u_fd_latch (
        .clock (clock),
        .reset (reset),
        .load  (fd_load),
        .clear (fd_clear),
        .d     (fd_d),
        .q     (fd_q)
    );

`ifdef FETCH_PERF_EN
    // Performance counters: accepted fetches and non-BOOT cycles that neither fetched nor redirected.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (accept) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state_q != BOOT) && !accept && !redirect_en) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule
